// File: rtl/gb_apu_frame_sequencer.sv
// gb_apu_frame_sequencer: 512 Hz 8-step frame sequencer emitting length/sweep/envelope strobes.
// Define GB_APU_FRAME_SEQ_EXT_DIV_EN to take step ticks from div_apu_tick instead of the internal divider.
module gb_apu_frame_sequencer #(
  parameter int CLK_DIV = 8192,
  localparam int DIV_W = $clog2(CLK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
`ifdef GB_APU_FRAME_SEQ_EXT_DIV_EN
  input  logic       div_apu_tick,
`endif
  output logic       clk_length,
  output logic       clk_vol_env,
  output logic       clk_sweep,
  output logic [2:0] frame_step
);
  logic       w_tick;
  logic [2:0] r_step;
`ifdef GB_APU_FRAME_SEQ_EXT_DIV_EN
  assign w_tick = div_apu_tick;
`else
  logic [DIV_W-1:0] r_div;
  assign w_tick = r_div == DIV_W'(CLK_DIV - 1);
  always_ff @(posedge clk)
    r_div <= (reset || !apu_enable || w_tick) ? '0 : r_div + 1'b1;
`endif
  // Strobes decode the step being executed; frame_step then points at the next one.
  always_ff @(posedge clk) begin
    if (reset || !apu_enable) begin
      r_step      <= '0;
      clk_length  <= 1'b0;
      clk_sweep   <= 1'b0;
      clk_vol_env <= 1'b0;
    end else begin
      clk_length  <= w_tick && !r_step[0];
      clk_sweep   <= w_tick && r_step[1:0] == 2'd2;
      clk_vol_env <= w_tick && r_step == 3'd7;
      if (w_tick) r_step <= r_step + 3'd1;
    end
  end
  assign frame_step = r_step;
endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// tb_gb_apu_frame_sequencer: directed checks of cadence, rates, disable and reset behaviour (CLK_DIV=4).
module tb_gb_apu_frame_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       apu_enable = 1'b0;
  logic       div_apu_tick = 1'b0;
  logic       clk_length, clk_vol_env, clk_sweep;
  logic [2:0] frame_step;
  int total = 0;
  int bad = 0;

  gb_apu_frame_sequencer #(.CLK_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .apu_enable(apu_enable),
`ifdef GB_APU_FRAME_SEQ_EXT_DIV_EN
    .div_apu_tick(div_apu_tick),
`endif
    .clk_length(clk_length),
    .clk_vol_env(clk_vol_env),
    .clk_sweep(clk_sweep),
    .frame_step(frame_step)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apu_enable = 1'b0;
    step();
    step();
    total++;
    if ({clk_length, clk_sweep, clk_vol_env, frame_step} !== 6'b0) begin
      bad++;
      $display("FAIL reset: got l=%b s=%b v=%b step=%0d want all 0", clk_length, clk_sweep, clk_vol_env, frame_step);
    end
    reset = 1'b0;
  endtask

  // Expects apu_enable already 1 with divider and step freshly cleared.
  task automatic check_cadence(input string nm);
    logic el, es, ev;
    logic [2:0] ef;
    for (int n = 1; n <= 32; n++) begin
      step();
      el = (n == 4) || (n == 12) || (n == 20) || (n == 28);
      es = (n == 12) || (n == 28);
      ev = (n == 32);
      ef = 3'((n / 4) % 8);
      total++;
      if ({clk_length, clk_sweep, clk_vol_env} !== {el, es, ev} || frame_step !== ef) begin
        bad++;
        $display("FAIL %s edge %0d: got l=%b s=%b v=%b step=%0d want l=%b s=%b v=%b step=%0d",
                 nm, n, clk_length, clk_sweep, clk_vol_env, frame_step, el, es, ev, ef);
      end
    end
  endtask

  task automatic test_power_on();
    apu_enable = 1'b1;
    check_cadence("power_on");
  endtask

  task automatic test_long_run();
    int nl, ns, nv, wide;
    logic pl, ps, pv;
    nl = 0; ns = 0; nv = 0; wide = 0;
    pl = 0; ps = 0; pv = 0;
    apu_enable = 1'b0;
    step();
    apu_enable = 1'b1;
    for (int i = 0; i < 640; i++) begin
      step();
      nl += int'(clk_length);
      ns += int'(clk_sweep);
      nv += int'(clk_vol_env);
      if ((pl && clk_length) || (ps && clk_sweep) || (pv && clk_vol_env)) wide++;
      pl = clk_length; ps = clk_sweep; pv = clk_vol_env;
    end
    total++;
    if (nl != 80) begin bad++; $display("FAIL long_length: got %0d want 80", nl); end
    total++;
    if (ns != 40) begin bad++; $display("FAIL long_sweep: got %0d want 40", ns); end
    total++;
    if (nv != 20) begin bad++; $display("FAIL long_vol_env: got %0d want 20", nv); end
    total++;
    if (wide != 0) begin bad++; $display("FAIL long_width: got %0d multi-cycle strobes want 0", wide); end
  endtask

  task automatic test_disable();
    apu_enable = 1'b0;
    step();
    apu_enable = 1'b1;
    repeat (18) step();
    total++;
    if (frame_step !== 3'd4) begin bad++; $display("FAIL dis_prestep: got %0d want 4", frame_step); end
    apu_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({clk_length, clk_sweep, clk_vol_env, frame_step} !== 6'b0) begin
        bad++;
        $display("FAIL dis_idle %0d: got l=%b s=%b v=%b step=%0d want all 0", i, clk_length, clk_sweep, clk_vol_env, frame_step);
      end
    end
    apu_enable = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      total++;
      if ({clk_length, clk_sweep, clk_vol_env} !== {n == 4, 1'b0, 1'b0} || frame_step !== ((n == 4) ? 3'd1 : 3'd0)) begin
        bad++;
        $display("FAIL dis_reenable edge %0d: got l=%b s=%b v=%b step=%0d", n, clk_length, clk_sweep, clk_vol_env, frame_step);
      end
    end
  endtask

  task automatic test_sync_reset();
    apu_enable = 1'b0;
    step();
    apu_enable = 1'b1;
    repeat (24) step();
    total++;
    if (frame_step !== 3'd6) begin bad++; $display("FAIL rst_prestep: got %0d want 6", frame_step); end
    reset = 1'b1;
    step();
    total++;
    if ({clk_length, clk_sweep, clk_vol_env, frame_step} !== 6'b0) begin
      bad++;
      $display("FAIL rst_clear: got l=%b s=%b v=%b step=%0d want all 0", clk_length, clk_sweep, clk_vol_env, frame_step);
    end
    reset = 1'b0;
    check_cadence("rst_restart");
  endtask

  task automatic test_ext_div();
    logic el, es, ev;
    apu_enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      div_apu_tick = 1'b1;
      step();
      div_apu_tick = 1'b0;
      el = k[0];
      es = (k % 4) == 3;
      ev = (k % 8) == 0;
      total++;
      if ({clk_length, clk_sweep, clk_vol_env} !== {el, es, ev} || frame_step !== 3'(k % 8)) begin
        bad++;
        $display("FAIL ext tick %0d: got l=%b s=%b v=%b step=%0d want l=%b s=%b v=%b step=%0d",
                 k, clk_length, clk_sweep, clk_vol_env, frame_step, el, es, ev, k % 8);
      end
      for (int i = 0; i < 4; i++) begin
        step();
        total++;
        if ({clk_length, clk_sweep, clk_vol_env} !== 3'b0) begin
          bad++;
          $display("FAIL ext gap %0d/%0d: got l=%b s=%b v=%b want 0", k, i, clk_length, clk_sweep, clk_vol_env);
        end
      end
    end
    apu_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      div_apu_tick = 1'b1;
      step();
      div_apu_tick = 1'b0;
      step();
      total++;
      if ({clk_length, clk_sweep, clk_vol_env, frame_step} !== 6'b0) begin
        bad++;
        $display("FAIL ext_disabled %0d: got l=%b s=%b v=%b step=%0d want 0", k, clk_length, clk_sweep, clk_vol_env, frame_step);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef GB_APU_FRAME_SEQ_EXT_DIV_EN
    test_ext_div();
`else
    test_power_on();
    test_long_run();
    test_disable();
    test_sync_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gb_apu_frame_sequencer.md
Name: gb_apu_frame_sequencer

Overview:
- Frame sequencer for the APU. Divides the system clock down to a 512 Hz step rate and walks an 8-step schedule.
- Emits the single-cycle enable strobes consumed by the channel function blocks: clk_vol_env feeds the envelope units, clk_length feeds the length counters, clk_sweep feeds the channel-1 sweep unit.
- Sits between the APU top level (power control from NR52) and all per-channel function modules.

Parameters:
- CLK_DIV, 8192, system clocks per sequencer step (4.194304 MHz / 512 Hz). Legal range ≥ 2.
- DIV_W, $clog2(CLK_DIV), width of the internal divider. Derived; do not override.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- apu_enable  input  1  NR52 bit 7 (APU power); 0 holds the sequencer idle
- clk_length  output  1  one-cycle strobe, 256 Hz, to length counters
- clk_vol_env  output  1  one-cycle strobe, 64 Hz, to envelope units
- clk_sweep  output  1  one-cycle strobe, 128 Hz, to channel-1 sweep
- frame_step  output  3  step index that the next tick will execute (drives the channel length-trigger quirk logic)

Behaviour:
- Reset (reset=1 at posedge):
  - divider ← 0, frame_step ← 0.
  - clk_length, clk_vol_env, clk_sweep ← 0.
  - Reset has priority over every other input.
- Disabled (apu_enable=0):
  - divider and frame_step are forced to 0 each cycle; all strobes ← 0.
  - Deasserting apu_enable mid-step discards the partial step count. No strobe is produced on the disable edge.
- Enabled, divider:
  - Increments by 1 per clk.
  - When divider == CLK_DIV−1, the divider wraps to 0 and a step tick occurs on that edge.
- Step tick, on the same edge:
  - Strobes are registered from the current frame_step:
    - Steps 0, 2, 4, 6 → clk_length=1.
    - Steps 2, 6 → clk_sweep=1.
    - Step 7 → clk_vol_env=1.
    - Steps 1, 3, 5 → no strobe.
  - frame_step ← frame_step+1, wrapping 7→0.
- Strobe timing:
  - Strobes are high for exactly one cycle: the cycle after the tick edge. They clear on the next edge.
  - Strobes are registered outputs; there is no combinational path from any input.
- Latency: after a power-on (apu_enable 0→1), the first step tick executes step 0 on the CLK_DIV-th enabled edge.
- Period: a full frame is 8×CLK_DIV cycles. Per frame: 4 clk_length, 2 clk_sweep and 1 clk_vol_env strobes.
- Coincident strobes: at steps 2 and 6, clk_length and clk_sweep assert in the same cycle. clk_vol_env never coincides with either.
- Re-enable: apu_enable 0→1 always restarts at step 0 with divider 0, regardless of where the sequencer was when it was disabled.
- Reset mid-frame: identical to a power-on. The next tick executes step 0.

Optional Feature:
- Macro: GB_APU_FRAME_SEQ_EXT_DIV_EN.
- Defined:
  - Adds input port div_apu_tick (1 bit): a one-cycle pulse from the timer block on the falling edge of DIV bit 4.
  - The internal divider and CLK_DIV are unused. A step tick occurs on any edge where div_apu_tick=1 and apu_enable=1.
  - All other rules are unchanged (strobe decode, one-cycle registered strobes, reset/disable clearing).
  - div_apu_tick while apu_enable=0 is ignored.
- Undefined: div_apu_tick does not exist, and the internal CLK_DIV divider generates ticks as above.

Test Plan:
- Power-on cadence (CLK_DIV=4): reset for 2 cycles, then apu_enable=1. Strobes occur in the cycle after enabled edges 4, 12, 20, 28 (clk_length); 12, 28 (clk_sweep); 32 (clk_vol_env). frame_step reads 1 after edge 4 and 0 after edge 32.
- Long-run rates (CLK_DIV=4, 640 cycles enabled): exactly 80 clk_length, 40 clk_sweep and 20 clk_vol_env strobes. Every strobe is exactly 1 cycle wide.
- Disable mid-frame: enable, run 18 cycles (frame_step=4), drop apu_enable for 3 cycles, re-enable. All strobes stay 0 while disabled. The first strobe after re-enable is clk_length on enabled edge 4, with frame_step=1 afterwards.
- Synchronous reset with enable held: at frame_step=6, pulse reset 1 cycle. Outputs and frame_step are 0 on the next edge, and the cadence restarts identically to the power-on case.
- Envelope integration: drive gb_apu_function_envelope's clk_vol_env from this block (CLK_DIV=4), with initial_volume=0, increasing, 1 sweep per tick. target_vol increments once per 32 cycles and saturates at 4'b1111.
- GB_APU_FRAME_SEQ_EXT_DIV_EN defined: 16 div_apu_tick pulses spaced 5 cycles apart produce clk_length on ticks 1, 3, 5, 7, 9, 11, 13, 15; clk_sweep on ticks 3, 7, 11, 15; clk_vol_env on ticks 8, 16. Pulses issued while apu_enable=0 produce no strobes.
